uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports configurable data width, parity and stop-bit count. Adds start-bit glitch rejection, parity/framing error reporting, and a valid/ready output handshake with overrun detection. Sits between the pad-side serial input and a byte sink (FIFO or command decoder) in the same clock domain.

---
 rtl/uart_rx_cfg.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1/2 stops.
// Start-glitch rejection, break handling and a valid/ready output with overrun.
module uart_rx_cfg #(
   parameter int CLKS_PER_BAUD = 868,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_rx,
   input  logic                 i_rx_ready,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_dvalid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_busy
);
   localparam int CW = $clog2(CLKS_PER_BAUD) + 1;
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BAUD / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BAUD - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
   localparam logic          ODD  = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 dvalid_q, dvalid_d;
   logic                 pe_q, pe_d;
   logic                 fe_q, fe_d;
   logic                 ovr_q, ovr_d;
   logic                 rx_s, tick, done;

   assign rx_s = sync2_q;
   assign tick = (cnt_q == '0);

   always_comb begin
      sync1_d  = i_rx;
      sync2_d  = sync1_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      data_d   = data_q;
      dvalid_d = dvalid_q;
      pe_d     = pe_q;
      fe_d     = fe_q;
      ovr_d    = ovr_q;
      done     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               cnt_d   = HALF;
               state_d = S_START;
            end
         end
         S_START: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!rx_s) begin
               cnt_d   = FULL;
               bit_d   = '0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               state_d = S_DATA;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               cnt_d   = FULL;
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST)
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP1;
            end
         end
         S_PARITY: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               perr_d  = ((^shift_q) ^ rx_s) != ODD;
               cnt_d   = FULL;
               state_d = S_STOP1;
            end
         end
         S_STOP1: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               ferr_d = !rx_s;
               if (STOP_BITS == 2) begin
                  cnt_d   = FULL;
                  state_d = S_STOP2;
               end else begin
                  done    = 1'b1;
                  state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
               end
            end
         end
         S_STOP2: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               ferr_d  = ferr_q | !rx_s;
               done    = 1'b1;
               state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            // a held-low line must not be mistaken for a new start bit
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (dvalid_q && i_rx_ready) begin
         dvalid_d = 1'b0;
         ovr_d    = 1'b0;
      end
      if (done) begin
         if (!dvalid_q || i_rx_ready) begin
            data_d   = shift_q;
            pe_d     = perr_q;
            fe_d     = ferr_d;
            dvalid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         data_q   <= '0;
         dvalid_q <= 1'b0;
         pe_q     <= 1'b0;
         fe_q     <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         data_q   <= data_d;
         dvalid_q <= dvalid_d;
         pe_q     <= pe_d;
         fe_q     <= fe_d;
         ovr_q    <= ovr_d;
      end
   end

   assign o_rx_data    = data_q;
   assign o_rx_dvalid  = dvalid_q;
   assign o_parity_err = pe_q;
   assign o_frame_err  = fe_q;
   assign o_overrun    = ovr_q;
   assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E2 instance driven by a bit-level
// line model; received words are compared against expected frame contents.
module tb_uart_rx_cfg;
   localparam int C = 16;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic       rx_a = 1'b1, rdy_a = 1'b1;
   logic [7:0] data_a;
   logic       dv_a, pe_a, fe_a, ov_a, busy_a;
   logic       rx_b = 1'b1, rdy_b = 1'b1;
   logic [6:0] data_b;
   logic       dv_b, pe_b, fe_b, ov_b, busy_b;

   uart_rx_cfg #(.CLKS_PER_BAUD(C), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1)) ua (
      .i_clk(clk), .i_rstn(rstn), .i_rx(rx_a), .i_rx_ready(rdy_a),
      .o_rx_data(data_a), .o_rx_dvalid(dv_a), .o_parity_err(pe_a),
      .o_frame_err(fe_a), .o_overrun(ov_a), .o_busy(busy_a));

   uart_rx_cfg #(.CLKS_PER_BAUD(C), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2)) ub (
      .i_clk(clk), .i_rstn(rstn), .i_rx(rx_b), .i_rx_ready(rdy_b),
      .o_rx_data(data_b), .o_rx_dvalid(dv_b), .o_parity_err(pe_b),
      .o_frame_err(fe_b), .o_overrun(ov_b), .o_busy(busy_b));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int dv_cnt_a = 0;
   int busy_cnt_a = 0;
   int rise_a = -1;
   logic dv_prev_a = 1'b0;
   logic [10:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

   always @(posedge clk) cyc <= cyc + 1;

   // accepted words are logged on the falling edge, away from DUT updates
   always @(negedge clk) begin
      if (rstn) begin
         if (dv_a) dv_cnt_a <= dv_cnt_a + 1;
         if (dv_a && !dv_prev_a) rise_a <= cyc;
         if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
         if (dv_a && rdy_a) got_a.push_back({pe_a, fe_a, 1'b0, data_a});
         if (dv_b && rdy_b) got_b.push_back({pe_b, fe_b, 2'b00, data_b});
      end
      dv_prev_a <= dv_a;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int which, input logic v, input int n);
      if (which == 0) rx_a = v;
      else rx_b = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int which, input logic [8:0] d, input int db,
                       input int pm, input logic flip, input logic s1,
                       input logic s2, input int ns);
      logic p;
      p = 1'b0;
      drive(which, 1'b0, C);
      for (int k = 0; k < db; k++) begin
         drive(which, d[k], C);
         p = p ^ d[k];
      end
      if (pm != 0) begin
         if (pm == 2) p = ~p;
         drive(which, p ^ flip, C);
      end
      drive(which, s1, C);
      if (ns == 2) drive(which, s2, C);
      drive(which, 1'b1, 2 * C);
   endtask

   task automatic drain(input int which, input string tag);
      logic [10:0] e, g;
      if (which == 0) begin
         chk({tag, " count"}, got_a.size(), exp_a.size());
         while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            g = (got_a.size() > 0) ? got_a.pop_front() : 11'h7FF;
            chk({tag, " word"}, g, e);
         end
         got_a.delete();
      end else begin
         chk({tag, " count"}, got_b.size(), exp_b.size());
         while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            g = (got_b.size() > 0) ? got_b.pop_front() : 11'h7FF;
            chk({tag, " word"}, g, e);
         end
         got_b.delete();
      end
   endtask

   initial begin
      int p0, dc, bc;
      logic [8:0] d;
      logic s1, s2, fl;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst data", data_a, 8'h00);
      chk("rst dvalid", dv_a, 1'b0);
      chk("rst perr", pe_a, 1'b0);
      chk("rst ferr", fe_a, 1'b0);
      chk("rst ovr", ov_a, 1'b0);
      chk("rst busy", busy_a, 1'b0);
      rstn = 1'b1;
      drive(0, 1'b1, 2 * C);

      // 8N1 0xA5: one-cycle pulse, one cycle after the stop sample
      dc = dv_cnt_a;
      p0 = cyc;
      send(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      exp_a.push_back({2'b00, 9'h0A5});
      drain(0, "a5");
      chk("a5 pulse len", dv_cnt_a - dc, 1);
      chk("a5 pulse time", rise_a, p0 + 3 + C / 2 + 9 * C);

      // random 8N1 frames, some with a low stop bit
      for (int i = 0; i < 6; i++) begin
         d = 9'($urandom_range(0, 255));
         s1 = ($urandom_range(0, 3) != 0);
         send(0, d, 8, 0, 1'b0, s1, 1'b1, 1);
         exp_a.push_back({1'b0, ~s1, d});
         drain(0, "rand8n1");
      end

      // 7E2 directed, good parity then flipped parity
      send(1, 9'h035, 7, 1, 1'b0, 1'b1, 1'b1, 2);
      exp_b.push_back({2'b00, 9'h035});
      send(1, 9'h035, 7, 1, 1'b1, 1'b1, 1'b1, 2);
      exp_b.push_back({2'b10, 9'h035});
      drain(1, "7e2 35");

      // random 7E2 frames with parity and stop faults
      for (int i = 0; i < 6; i++) begin
         d = 9'($urandom_range(0, 127));
         fl = 1'($urandom_range(0, 1));
         s1 = ($urandom_range(0, 3) != 0);
         s2 = ($urandom_range(0, 3) != 0);
         send(1, d, 7, 1, fl, s1, s2, 2);
         exp_b.push_back({fl, ~(s1 & s2), d});
         drain(1, "rand7e2");
      end
      chk("b ovr", ov_b, 1'b0);

      // short low glitch: busy for half a bit, no word
      dc = dv_cnt_a;
      bc = busy_cnt_a;
      drive(0, 1'b0, 4);
      drive(0, 1'b1, 2 * C);
      chk("glitch busy", busy_cnt_a - bc, C / 2);
      chk("glitch dv", dv_cnt_a - dc, 0);
      drain(0, "glitch");

      // break: three frame times low gives one errored zero word
      drive(0, 1'b0, 30 * C);
      chk("break busy", busy_a, 1'b1);
      drive(0, 1'b1, 2 * C);
      chk("break idle", busy_a, 1'b0);
      exp_a.push_back({2'b01, 9'h000});
      drain(0, "break");

      // overrun: second word dropped while first is held
      rdy_a = 1'b0;
      send(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      send(0, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      chk("ovr held dv", dv_a, 1'b1);
      chk("ovr held data", data_a, 8'h11);
      chk("ovr flag", ov_a, 1'b1);
      rdy_a = 1'b1;
      @(posedge clk);
      #1;
      rdy_a = 1'b0;
      chk("ovr xfer dv", dv_a, 1'b0);
      chk("ovr xfer flag", ov_a, 1'b0);
      rdy_a = 1'b1;
      exp_a.push_back({2'b00, 9'h011});
      drain(0, "ovr");

      // reset mid-frame with a word held and overrun set
      rdy_a = 1'b0;
      send(0, 9'h033, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      send(0, 9'h044, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      chk("pre-rst ovr", ov_a, 1'b1);
      drive(0, 1'b0, C);
      drive(0, 1'b0, C);
      drive(0, 1'b1, C);
      drive(0, 1'b0, C);
      drive(0, 1'b1, C / 2);
      chk("mid busy", busy_a, 1'b1);
      rstn = 1'b0;
      drive(0, 1'b1, 3);
      chk("mrst data", data_a, 8'h00);
      chk("mrst dvalid", dv_a, 1'b0);
      chk("mrst perr", pe_a, 1'b0);
      chk("mrst ferr", fe_a, 1'b0);
      chk("mrst ovr", ov_a, 1'b0);
      chk("mrst busy", busy_a, 1'b0);
      drive(0, 1'b1, 6 * C);
      rstn = 1'b1;
      rdy_a = 1'b1;
      drive(0, 1'b1, 2 * C);
      send(0, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      exp_a.push_back({2'b00, 9'h05A});
      drain(0, "post rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
